// File: rtl/count_seq_checker_if.sv
// Sample/control and status bundle between an upstream 4-bit counter source and count_seq_checker.
interface count_seq_checker_if;
    logic       IN_EN;
    logic [3:0] IN_CNT;
    logic       CLR_ERR;
    logic       LOCKED;
    logic       ERR;
    logic [7:0] ERR_CNT;
    logic [7:0] WRAP_CNT;
    logic [3:0] EXP;

    modport master (
        output IN_EN, IN_CNT, CLR_ERR,
        input  LOCKED, ERR, ERR_CNT, WRAP_CNT, EXP
    );

    modport slave (
        input  IN_EN, IN_CNT, CLR_ERR,
        output LOCKED, ERR, ERR_CNT, WRAP_CNT, EXP
    );
endinterface

// File: rtl/count_seq_checker.sv
// Checks that qualified samples from a 4-bit up-counter arrive in sequence,
// locking after SYNC_LEN consecutive matches and counting errors and wraps.
module count_seq_checker #(
    parameter int SYNC_LEN = 2
) (
    input logic                 Clk,
    input logic                 RST,
    count_seq_checker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

    localparam logic [3:0] LOCK_AT = 4'(SYNC_LEN);

    state_t     state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic [3:0] match_q, match_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] wrap_cnt_q, wrap_cnt_d;
    logic [7:0] err_base;
    logic       hit;

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            match_q    <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            match_q    <= match_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        match_d    = match_q;
        locked_d   = locked_q;
        wrap_cnt_d = wrap_cnt_q;
        hit        = (bus.IN_CNT == exp_q);
        // Clear is applied first so a same-edge mismatch counts from zero.
        err_base   = bus.CLR_ERR ? '0 : err_cnt_q;
        err_d      = bus.CLR_ERR ? 1'b0 : err_q;
        err_cnt_d  = err_base;

        if (bus.IN_EN) begin
            unique case (state_q)
                IDLE: begin
                    exp_d   = bus.IN_CNT + 4'd1;
                    match_d = 4'd1;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (hit) begin
                        exp_d   = exp_q + 4'd1;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_AT) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        exp_d   = bus.IN_CNT + 4'd1;
                        match_d = 4'd1;
                    end
                end
                TRACK: begin
                    if (hit) begin
                        exp_d = exp_q + 4'd1;
                        if (bus.IN_CNT == 4'd0 && wrap_cnt_q != 8'hFF)
                            wrap_cnt_d = wrap_cnt_q + 8'd1;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_base == 8'hFF) ? err_base : err_base + 8'd1;
                        locked_d  = 1'b0;
                        exp_d     = bus.IN_CNT + 4'd1;
                        match_d   = 4'd1;
                        state_d   = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.LOCKED   = locked_q;
    assign bus.ERR      = err_q;
    assign bus.ERR_CNT  = err_cnt_q;
    assign bus.WRAP_CNT = wrap_cnt_q;
    assign bus.EXP      = exp_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus random traffic checked
// every cycle against a run-length model of the counter stream.
module tb_count_seq_checker;
    localparam int SYNC_LEN = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   chk_on = 1'b0;

    count_seq_checker_if bus ();

    count_seq_checker #(.SYNC_LEN(SYNC_LEN)) dut (
        .Clk (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: EXP is last sample + 1; lock follows a run of consecutive +1 samples.
    bit m_have_prev;
    int m_prev;
    int m_run;
    bit m_locked;
    bit m_err;
    int m_err_cnt;
    int m_wrap;

    function automatic int m_exp();
        return m_have_prev ? (m_prev + 1) % 16 : 0;
    endfunction

    task automatic model_update(input logic r, input logic e, input int c, input logic cl);
        bit seq;
        if (r) begin
            m_have_prev = 0; m_prev = 0; m_run = 0; m_locked = 0;
            m_err = 0; m_err_cnt = 0; m_wrap = 0;
            return;
        end
        if (cl) begin
            m_err = 0;
            m_err_cnt = 0;
        end
        if (e) begin
            seq   = m_have_prev && (c == (m_prev + 1) % 16);
            m_run = seq ? m_run + 1 : 1;
            if (m_run > 1000) m_run = 1000;
            if (m_locked) begin
                if (seq) begin
                    if (c == 0 && m_wrap < 255) m_wrap++;
                end else begin
                    m_err = 1;
                    if (m_err_cnt < 255) m_err_cnt++;
                    m_locked = 0;
                end
            end else if (m_run >= SYNC_LEN) begin
                m_locked = 1;
            end
            m_prev = c;
            m_have_prev = 1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_LOCKED",   int'(bus.LOCKED),   int'(m_locked));
            check("cyc_ERR",      int'(bus.ERR),      int'(m_err));
            check("cyc_ERR_CNT",  int'(bus.ERR_CNT),  m_err_cnt);
            check("cyc_WRAP_CNT", int'(bus.WRAP_CNT), m_wrap);
            check("cyc_EXP",      int'(bus.EXP),      m_exp());
        end
    end

    task automatic step(input logic r, input logic e, input int c, input logic cl);
        rst         = r;
        bus.IN_EN   = e;
        bus.IN_CNT  = 4'(c);
        bus.CLR_ERR = cl;
        @(posedge clk);
        model_update(r, e, c, cl);
        #1;
    endtask

    task automatic sample(input int c);
        step(1'b0, 1'b1, c, 1'b0);
    endtask

    initial begin
        int v;
        logic r, e, cl;
        int c;

        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 9, 1'b1);
        chk_on = 1'b1;
        check("rst_LOCKED", int'(bus.LOCKED), 0);
        check("rst_ERR_CNT", int'(bus.ERR_CNT), 0);
        check("rst_EXP", int'(bus.EXP), 0);

        // Straight count 0..15,0,1
        sample(0);
        sample(1);
        check("seq_locked_after_2", int'(bus.LOCKED), 1);
        for (int i = 2; i < 16; i++) sample(i);
        check("seq_wrap_before_0", int'(bus.WRAP_CNT), 0);
        sample(0);
        check("seq_wrap_after_0", int'(bus.WRAP_CNT), 1);
        sample(1);
        check("seq_err", int'(bus.ERR), 0);
        check("seq_exp_end", int'(bus.EXP), 2);

        // Mismatch while locked, then resync
        step(1'b1, 1'b0, 0, 1'b0);
        sample(3); sample(4); sample(5); sample(6);
        sample(9);
        check("mis_err", int'(bus.ERR), 1);
        check("mis_err_cnt", int'(bus.ERR_CNT), 1);
        check("mis_locked", int'(bus.LOCKED), 0);
        check("mis_exp", int'(bus.EXP), 10);
        sample(10);
        check("mis_relock", int'(bus.LOCKED), 1);

        // Unqualified samples are ignored
        step(1'b1, 1'b0, 0, 1'b0);
        sample(1); sample(2);
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b0, 7, 1'b0);
        step(1'b0, 1'b0, 8, 1'b0);
        step(1'b0, 1'b1, 4, 1'b0);
        check("en_err", int'(bus.ERR), 0);
        check("en_exp", int'(bus.EXP), 5);
        check("en_locked", int'(bus.LOCKED), 1);

        // Clear coinciding with a mismatch
        sample(9); sample(10); sample(0); sample(1); sample(7); sample(8);
        check("clr_pre_cnt", int'(bus.ERR_CNT), 3);
        step(1'b0, 1'b1, 0, 1'b1);
        check("clr_same_err", int'(bus.ERR), 1);
        check("clr_same_cnt", int'(bus.ERR_CNT), 1);
        step(1'b0, 1'b0, 0, 1'b1);
        check("clr_alone_err", int'(bus.ERR), 0);
        check("clr_alone_cnt", int'(bus.ERR_CNT), 0);

        // Error counter saturation
        sample(1);
        for (int i = 0; i < 300; i++) begin
            v = (m_exp() + 2) % 16;
            sample(v);
            sample((v + 1) % 16);
        end
        check("sat_err_cnt", int'(bus.ERR_CNT), 255);
        check("sat_locked", int'(bus.LOCKED), 1);

        // Reset mid-TRACK
        step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i <= 64; i++) sample(i % 16);
        check("rtrk_wrap", int'(bus.WRAP_CNT), 4);
        step(1'b1, 1'b1, 1, 1'b0);
        check("rtrk_locked", int'(bus.LOCKED), 0);
        check("rtrk_wrap0", int'(bus.WRAP_CNT), 0);
        check("rtrk_exp", int'(bus.EXP), 0);
        sample(7);
        check("rtrk_resume_exp", int'(bus.EXP), 8);
        check("rtrk_resume_locked", int'(bus.LOCKED), 0);

        // Random traffic
        v = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 19) == 0);
            if (e) begin
                if ($urandom_range(0, 11) == 0) v = $urandom_range(0, 15);
                else v = (v + 1) % 16;
                c = v;
            end else begin
                c = $urandom_range(0, 15);
            end
            step(r, e, c, cl);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
